// File: rtl/serial_word_packer_if.sv
// Bus between the serial word packer and its neighbours: serial symbol input,
// parallel word output handshake and overflow flag. Frame exists only with SWP_FRAME_EN.
interface serial_word_packer_if #(
  parameter int pwidth = 32,
  parameter int swidth = 1
);
  logic [swidth-1:0] SIn;
  logic              SInValid;
`ifdef SWP_FRAME_EN
  logic              Frame;
`endif
  logic [pwidth-1:0] POut;
  logic              POutValid;
  logic              POutReady;
  logic              Overflow;

  // Output handshake: a word moves on any rising edge where POutValid and POutReady
  // are both 1. POut/POutValid never change while POutValid=1 and POutReady=0, and
  // POutValid never depends combinationally on POutReady. SIn has no backpressure.
  modport master (
`ifdef SWP_FRAME_EN
    output Frame,
`endif
    output SIn, SInValid, POutReady,
    input  POut, POutValid, Overflow
  );

  modport slave (
`ifdef SWP_FRAME_EN
    input  Frame,
`endif
    input  SIn, SInValid, POutReady,
    output POut, POutValid, Overflow
  );
endinterface

// File: rtl/serial_word_packer.sv
// Packs MSB-first serial symbols into pwidth-bit words behind a 2-entry output FIFO.
// Optional macro SWP_FRAME_EN adds the Frame input that restarts word alignment.
module serial_word_packer #(
  parameter int pwidth = 32,
  parameter int swidth = 1
) (
  input logic                  Clock,
  input logic                  Reset,
  serial_word_packer_if.slave  bus
);
  localparam int N  = pwidth / swidth;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]     cnt_q, cnt_d, cnt_base;
  logic [pwidth-1:0] part_q, part_d, word;
  logic              start, complete, pop, full;

  logic [pwidth-1:0] mem_q [2];
  logic [pwidth-1:0] mem_d [2];
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        occ_q, occ_d;
  logic [pwidth-1:0] pout_q, pout_d;
  logic              pv_q, pv_d, ovf_q, ovf_d;

  // Symbol assembly; a framed symbol starts from an empty word at count 0.
  always_comb begin
`ifdef SWP_FRAME_EN
    start = bus.SInValid & bus.Frame;
`else
    start = 1'b0;
`endif
    cnt_base = start ? '0 : cnt_q;
    word     = start ? pwidth'(bus.SIn) : ((part_q << swidth) | pwidth'(bus.SIn));
    complete = bus.SInValid && (cnt_base == CW'(N - 1));
    cnt_d    = cnt_q;
    part_d   = part_q;
    if (bus.SInValid) begin
      if (complete) begin
        cnt_d  = '0;
        part_d = '0;
      end else begin
        cnt_d  = cnt_base + CW'(1);
        part_d = word;
      end
    end
  end

  // FIFO update; the output register always mirrors the post-edge head entry.
  always_comb begin
    pop   = pv_q & bus.POutReady;
    full  = (occ_q == 2'd2);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (complete && full && !pop) begin
      ovf_d = 1'b1;
    end else begin
      if (complete) begin
        mem_d[wr_q] = word;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      case ({complete, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
    pv_d   = (occ_d != 2'd0);
    pout_d = pv_d ? mem_d[rd_d] : pout_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q    <= '0;
      part_q   <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
      pout_q   <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      occ_q    <= occ_d;
      pout_q   <= pout_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.POut      = pout_q;
  assign bus.POutValid = pv_q;
  assign bus.Overflow  = ovf_q;
endmodule

// File: doc/serial_word_packer.md
SERIAL_WORD_PACKER -- requirements
Module: serial_word_packer

Interface
REQ-001 Parameter pwidth, default 32, SHALL set the parallel output word width in bits.
REQ-002 Parameter swidth, default 1, SHALL set the serial symbol width in bits; pwidth SHALL be an integer multiple of swidth, with N = pwidth/swidth symbols per word.
REQ-003 Port Clock, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port Reset, input, 1: reset, synchronous and active-low.
REQ-005 Port SIn, input, swidth: serial symbol, driven from an upstream shift register's SOut.
REQ-006 Port SInValid, input, 1: SIn holds a valid symbol this cycle; there is no serial backpressure.
REQ-007 Port Frame, input, 1: word-boundary marker; present only when SWP_FRAME_EN is defined.
REQ-008 Port POut, output, pwidth: assembled word at the head of the output buffer.
REQ-009 Port POutValid, output, 1: POut holds a valid word.
REQ-010 Port POutReady, input, 1: downstream accepts POut this cycle.
REQ-011 Port Overflow, output, 1: sticky flag indicating a completed word was dropped.

Function
REQ-012 A symbol SHALL be accepted on every cycle with SInValid=1; when SInValid=0, the symbol counter and the partial word SHALL hold.
REQ-013 Packing SHALL be MSB-first: the partial word shifts left by swidth and SIn enters the LSBs, so the first symbol of a word lands in bits [pwidth-1:pwidth-swidth].
REQ-014 A symbol counter SHALL run 0..N-1; accepting the symbol at count N-1 SHALL complete the word and wrap the counter to 0.
REQ-015 A completed word SHALL be pushed into a 2-entry FIFO in the same edge that accepts its last symbol; POutValid SHALL assert the following cycle (latency 1 cycle from the final symbol).
REQ-016 A transfer SHALL occur when POutValid=1 and POutReady=1 in the same cycle; the FIFO SHALL pop on that edge.
REQ-017 POut and POutValid SHALL be driven from registers and SHALL be stable while POutValid=1 and POutReady=0.
REQ-018 If a push and a pop occur in the same cycle with the FIFO full, both SHALL complete; no overflow is flagged.
REQ-019 If a push occurs with the FIFO full and no pop, the new word SHALL be dropped, the FIFO contents SHALL be unchanged, and Overflow SHALL set and stay at 1 until reset.
REQ-020 If a push and a pop occur in the same cycle with the FIFO empty, this SHALL be impossible by construction (POutValid=0); the push SHALL be stored normally.
REQ-021 The FIFO SHALL preserve word order: read and write pointers are 1 bit each, plus an occupancy count 0..2.

Reset
REQ-022 While Reset=0 at a rising edge: counter=0, partial word=0, FIFO empty, POut=0, POutValid=0, Overflow=0.
REQ-023 Reset asserted mid-word or mid-handshake SHALL discard all partial and buffered data; no word SHALL be output for symbols accepted before the reset.
REQ-024 During the reset cycle, inputs SHALL be ignored; the first cycle with Reset=1 SHALL accept a symbol as count 0.

Configuration
REQ-025 With macro SWP_FRAME_EN defined, a cycle with Frame=1 and SInValid=1 SHALL discard any partial word and treat SIn as symbol 0 of a new word (counter becomes 1, or completes immediately if N=1); Frame=1 with SInValid=0 SHALL have no effect.
REQ-026 Without SWP_FRAME_EN, the Frame port SHALL be absent and the counter SHALL free-run per REQ-014 from reset.

Verification (pwidth=8, swidth=1 unless stated)
REQ-027 Serial input 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles with POutReady=1 -> POut=8'hA5 and POutValid=1 for exactly 1 cycle, one cycle after the 8th symbol.
REQ-028 With pwidth=32, swidth=8, bytes DE,AD,BE,EF -> POut=32'hDEADBEEF; SInValid gaps between bytes SHALL not change the result.
REQ-029 With POutReady=0, three words 8'h11, 8'h22, 8'h33 sent -> Overflow=1; after POutReady=1, 8'h11 then 8'h22 are transferred, and 8'h33 never appears.
REQ-030 With the FIFO full, the third word completes in the same cycle that POutReady=1 pops the head -> Overflow stays 0, and 3 words are delivered in order.
REQ-031 Reset=0 asserted after 5 of 8 symbols, then 8 symbols of 8'h3C -> the only word output is 8'h3C.
REQ-032 With SWP_FRAME_EN defined: 3 junk symbols, then Frame=1 on the first symbol of 8'hC3 -> the only word output is 8'hC3.
